// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, combinational head read and a
// flush that overrides any same-cycle push or pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only ever read behind the count.
    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order imem requests under a credit limit, PC-tagged
// instruction buffer toward decode, redirect with wrong-path response dropping.
//   IDLE  | first cycle after reset release, no requests
//   RUN   | normal fetching
//   FLUSH | discarding responses of requests issued before a redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0,
    parameter int                       FIFO_DEPTH   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_BITS-1:0]  imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [31:0]              imem_resp_data,
    input  logic                     next_PC_select,
    input  logic [ADDRESS_BITS-1:0]  target_PC,
    output logic [ADDRESS_BITS-1:0]  PC,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    input  logic                     decode_ready
);

    localparam int                      CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]             DEPTH_LIM  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

    fetch_state_e state_q, state_d;

    logic [ADDRESS_BITS-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]              drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]              tag_count, fifo_count;
    logic                       tag_full, tag_empty, fifo_full, fifo_empty;
    logic [ADDRESS_BITS-1:0]    tag_pc;
    logic [ADDRESS_BITS+31:0]   fifo_head;

    logic credit_ok, req_fire, resp_ok, fifo_push, fifo_pop;

    // The tag queue occupancy is the outstanding-request count.
    assign credit_ok = ({1'b0, tag_count} + {1'b0, fifo_count}) < DEPTH_LIM;
    assign req_fire  = imem_req_valid && imem_req_ready && !tag_full;
    assign resp_ok   = imem_resp_valid && !tag_empty;
    assign fifo_push = resp_ok && !next_PC_select && (drop_cnt_q == '0)
                       && (!fifo_full || fifo_pop);
    assign fifo_pop  = !fifo_empty && decode_ready && !next_PC_select;
    assign imem_req_addr = fetch_pc_q;

    sync_fifo #(
        .WIDTH (ADDRESS_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clock   (clock),
        .reset   (reset),
        .push_i  (req_fire),
        .pop_i   (resp_ok),
        .flush_i (1'b0),
        .wdata_i (fetch_pc_q),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count),
        .data_o  (tag_pc)
    );

    sync_fifo #(
        .WIDTH (ADDRESS_BITS + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_q (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (next_PC_select),
        .wdata_i ({tag_pc, imem_resp_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .data_o  (fifo_head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (next_PC_select) begin
            fetch_pc_d = target_PC & ALIGN_MASK;
            drop_cnt_d = tag_count - CW'(resp_ok);
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(PC_INC);
            if (resp_ok && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       state_d = RUN;
            RUN, FLUSH: state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q != IDLE) && !next_PC_select && credit_ok;
        instr_valid    = !fifo_empty;
        PC             = '0;
        instr          = NOP_INSTR;
        if (!fifo_empty) begin
            PC    = fifo_head[ADDRESS_BITS+31:32];
            instr = fifo_head[31:0];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// against a queue-based model of requests, outstanding tags and the decode buffer.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic [15:0] PC;
    logic [31:0] instr;
    logic        instr_valid, decode_ready;

    fetch_unit #(
        .ADDRESS_BITS (16),
        .RESET_PC     (16'h0000),
        .FIFO_DEPTH   (2)
    ) dut (
        .clock           (clock),
        .reset           (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .next_PC_select  (next_PC_select),
        .target_PC       (target_PC),
        .PC              (PC),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .decode_ready    (decode_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_t;

    mem_t        mem_q[$];
    logic [15:0] tag_q[$];
    bit          live_q[$];
    logic [47:0] out_q[$];
    logic [15:0] req_log[$];

    logic [15:0] m_pc;
    bit          m_started;
    int unsigned cyc, last_due;
    int          n_checks, n_fails;

    bit          sel, rdy, dready, stale_inject;
    logic [15:0] tgt;
    int unsigned lat_min, lat_max;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        tag_q.delete();
        live_q.delete();
        out_q.delete();
        m_pc      = 16'h0000;
        m_started = 0;
        last_due  = 0;
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs, advance model at posedge.
    task automatic step();
        bit          exp_rv, from_mem, push_item, live;
        logic [47:0] head, item;
        logic [15:0] t;
        mem_t        m;
        @(negedge clock);
        from_mem = 0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            from_mem = 1;
        end else if (stale_inject) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        next_PC_select = sel;
        target_PC      = tgt;
        imem_req_ready = rdy;
        decode_ready   = dready;
        #1;
        exp_rv = m_started && !sel && (tag_q.size() + out_q.size() < 2);
        check("req_valid", 48'(imem_req_valid), 48'(exp_rv));
        if (exp_rv) check("req_addr", 48'(imem_req_addr), 48'(m_pc));
        head = (out_q.size() > 0) ? out_q[0] : {16'h0000, NOP};
        check("instr_valid", 48'(instr_valid), 48'(out_q.size() > 0));
        check("pc", 48'(PC), 48'(head[47:32]));
        check("instr", 48'(instr), 48'(head[31:0]));
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);

        @(posedge clock);
        push_item = 0;
        item      = '0;
        if (imem_resp_valid) begin
            n_checks++;
            assert (tag_q.size() > 0 || stale_inject) else begin
                n_fails++;
                $error("FAIL resp_protocol: response with %0d outstanding, required >0", tag_q.size());
            end
            if (tag_q.size() > 0) begin
                t    = tag_q.pop_front();
                live = live_q.pop_front();
                item = {t, imem_resp_data};
                push_item = live && !sel;
            end
        end
        if (!sel && dready && out_q.size() > 0) void'(out_q.pop_front());
        if (push_item) out_q.push_back(item);
        if (sel) begin
            out_q.delete();
            foreach (live_q[i]) live_q[i] = 0;
            m_pc = tgt & 16'hFFFC;
        end
        if (from_mem) void'(mem_q.pop_front());
        if (exp_rv && rdy) begin
            tag_q.push_back(m_pc);
            live_q.push_back(1);
            m.addr = m_pc;
            m.data = $urandom;
            m.due  = cyc + $urandom_range(lat_max, lat_min);
            if (m.due <= last_due) m.due = last_due + 1;
            last_due = m.due;
            mem_q.push_back(m);
            m_pc = m_pc + 16'd4;
        end
        m_started = 1;
        cyc++;
    endtask

    task automatic fill_outstanding();
        for (int i = 0; i < 50 && tag_q.size() < 2; i++) step();
        check("fill_timeout", 48'(tag_q.size() >= 2), 48'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        next_PC_select = 1'b0; target_PC = '0; decode_ready = 1'b0;
        sel = 0; tgt = '0; rdy = 1; dready = 1; stale_inject = 0;
        lat_min = 1; lat_max = 1;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check("rst_req_valid", 48'(imem_req_valid), 48'(0));
        check("rst_instr_valid", 48'(instr_valid), 48'(0));
        check("rst_pc", 48'(PC), 48'(0));
        check("rst_instr", 48'(instr), 48'(NOP));
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Streaming with single-cycle memory latency
        req_log.delete();
        repeat (20) step();
        check("a_addr0", 48'(log_at(0)), 48'(16'h0000));
        check("a_addr1", 48'(log_at(1)), 48'(16'h0004));
        check("a_addr2", 48'(log_at(2)), 48'(16'h0008));

        // Decode backpressure
        dready = 0;
        repeat (10) step();
        dready = 1;
        repeat (10) step();

        // Redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        fill_outstanding();
        sel = 1; tgt = 16'h0123;
        req_log.delete();
        step();
        sel = 0;
        repeat (15) step();
        check("c_redirect_addr", 48'(log_at(0)), 48'(16'h0120));

        // Redirect coinciding with a response and a decode pop
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 50; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && out_q.size() > 0) break;
            step();
        end
        sel = 1; tgt = 16'h0040;
        step();
        #1 sel = 0; next_PC_select = 1'b0;
        #1;
        check("d_instr_valid", 48'(instr_valid), 48'(0));
        check("d_instr", 48'(instr), 48'(NOP));
        check("d_pc", 48'(PC), 48'(0));
        repeat (10) step();

        // Fetch PC wrap at the top of the address space
        lat_min = 1; lat_max = 1;
        sel = 1; tgt = 16'hFFF9;
        req_log.delete();
        step();
        sel = 0;
        repeat (12) step();
        check("e_addr0", 48'(log_at(0)), 48'(16'hFFF8));
        check("e_addr1", 48'(log_at(1)), 48'(16'hFFFC));
        check("e_wrap", 48'(log_at(2)), 48'(16'h0000));

        // Asynchronous reset with requests outstanding, then a stale response
        lat_min = 3; lat_max = 3;
        fill_outstanding();
        #3 reset_n = 1'b0;
        #1;
        check("f_rst_req_valid", 48'(imem_req_valid), 48'(0));
        check("f_rst_instr_valid", 48'(instr_valid), 48'(0));
        check("f_rst_instr", 48'(instr), 48'(NOP));
        model_reset();
        imem_resp_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        stale_inject = 1;
        req_log.delete();
        step();
        step();
        stale_inject = 0;
        repeat (10) step();
        check("f_first_addr", 48'(log_at(0)), 48'(16'h0000));

        // Random traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            rdy    = ($urandom_range(3, 0) != 0);
            dready = ($urandom_range(2, 0) != 0);
            sel    = ($urandom_range(11, 0) == 0);
            tgt    = 16'($urandom);
            step();
        end
        sel = 0; rdy = 1; dready = 1;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
